// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if
// Bundles the producer handshake and the serial line outputs of the frame
// transmitter so both ends can be wired with a single connection.
//
// Signals:
//   data_in    [DATA_W]  payload word offered by the producer
//   data_valid           producer has a word on data_in
//   data_ready           transmitter is idle and will take the word
//   out                  serial line, low when idle
//   busy                 frame in progress (markers, payload and gap)
//   done                 one-cycle pulse on the first gap cycle
//
// Modports:
//   master  producer / observer side (drives data_in, data_valid)
//   slave   transmitter side (drives data_ready, out, busy, done)
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              out;
  logic              busy;
  logic              done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx
// Serial frame transmitter for the Moore sequence detectors. A word taken
// over the valid/ready handshake is sent as the marker 1,0,1, then the
// payload MSB-first, then IDLE_GAP low cycles so the detector sees clean
// framing between frames.
//
// Parameters:
//   DATA_W    payload width in bits (1..32)
//   IDLE_GAP  number of low gap cycles after the payload (1..15)
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   reset  synchronous, active-high reset
//   bus    seq_frame_tx_if slave modport (handshake in, serial line out)
module seq_frame_tx #(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 2
) (
  input  logic         clk,
  input  logic         reset,
  seq_frame_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0]       GAP_LAST = 4'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    MK1,
    MK0,
    MK2,
    DATA,
    GAP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [CNT_W-1:0]  bit_q;
  logic [CNT_W-1:0]  bit_d;
  logic [3:0]        gap_q;
  logic [3:0]        gap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decode only registered state, so nothing on the handshake
  // inputs can reach the line or the status flags in the same cycle.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_d          = bit_q;
    gap_d          = gap_q;
    bus.out        = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.data_ready = 1'b0;

    case (state_q)
      IDLE: begin
        bus.data_ready = 1'b1;
        if (bus.data_valid) begin
          shift_d = bus.data_in;
          state_d = MK1;
        end
      end
      MK1: begin
        bus.out  = 1'b1;
        bus.busy = 1'b1;
        state_d  = MK0;
      end
      MK0: begin
        bus.busy = 1'b1;
        state_d  = MK2;
      end
      MK2: begin
        bus.out  = 1'b1;
        bus.busy = 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        bus.out  = shift_q[DATA_W-1];
        bus.busy = 1'b1;
        // A shift rather than a concatenation keeps DATA_W=1 legal.
        shift_d  = shift_q << 1;
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          state_d = GAP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      GAP: begin
        bus.busy = 1'b1;
        bus.done = (gap_q == 4'd0);
        if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Serial frame transmitter that drives a one-bit line read by the team's Moore sequence detectors. It accepts a parallel word over a valid/ready handshake and emits a frame on `out`. Each frame is the 3-bit marker 1,0,1, then the payload MSB-first, then a low inter-frame gap. The gap keeps the detector's sequence framing clean between frames.

Parameters:
DATA_W, 8, payload width in bits (legal 1..32)
IDLE_GAP, 2, number of low gap cycles after the payload (legal 1..15)

Ports:
clk  input  1  single clock; all state updates on posedge clk
reset  input  1  synchronous, active-high reset
data_in  input  DATA_W  payload word; sampled only on the accept edge
data_valid  input  1  producer has a word on data_in
data_ready  output  1  transmitter can accept a word; high only in IDLE
out  output  1  serial line; low when idle
busy  output  1  high from the first marker bit through the last gap cycle
done  output  1  one-cycle pulse on the first gap cycle after the last payload bit

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset; it is sampled only at posedge clk.
- Reset values (at the edge where reset=1): state=IDLE, out=0, data_ready=1, busy=0, done=0, shift register=0, bit counter=0.
- States:
  - IDLE: out=0, data_ready=1.
  - MK1: out=1.
  - MK0: out=0.
  - MK2: out=1.
  - DATA: out=shift[DATA_W-1].
  - GAP: out=0.
- Output decoding:
  - All outputs are Moore-decoded from registered state, counter and shift register; there is no combinational path from inputs to outputs.
  - busy=1 in MK1..GAP.
  - done=1 only in GAP while gap counter==0.
- Accept rule:
  - A word is accepted at a posedge where state==IDLE, data_valid=1 and reset=0.
  - On accept: shift<=data_in and next state=MK1.
  - data_valid while data_ready=0 is ignored; no queuing.
  - data_in is never sampled outside the accept edge.
- Transitions (reset has priority over all of them):
  - MK1->MK0->MK2->DATA unconditionally.
  - DATA holds for exactly DATA_W cycles. Each edge shifts left by one, fills with 0, and increments the bit counter. On the edge where counter==DATA_W-1: counter<=0, next state=GAP.
  - GAP holds for exactly IDLE_GAP cycles, then goes to IDLE.
- Latency: for an accept at edge k, out=1 (MK1) is visible after edge k. The first payload bit is visible after edge k+3.
- Frame length: 3+DATA_W+IDLE_GAP cycles of busy=1, then at least one IDLE cycle before the next accept.
- Throughput: with data_valid held high, consecutive frames start 4+DATA_W+IDLE_GAP cycles apart.
- Counter width: $clog2(DATA_W+1) bits for payload, 4 bits for gap. There is no wrap beyond the terminal counts.
- Reset mid-frame: the next edge returns to IDLE with out=0. The partial frame is abandoned, done is not pulsed and no word is retained.
- Reset coincident with data_valid: reset wins and the word is not accepted.
- Boundary cases:
  - DATA_W=1 gives exactly one DATA cycle.
  - IDLE_GAP=1 gives exactly one GAP cycle, with done high in it.

Test Plan:
- Reset: hold reset 2 cycles with data_valid=1 -> out=0, data_ready=1, busy=0, done=0; no frame starts.
- Single frame, DATA_W=8, IDLE_GAP=2, data_in=8'hA5 accepted at edge 0:
  - out after edges 0..12 = 1,0,1,1,0,1,0,0,1,0,1,0,0.
  - done=1 only after edge 11.
  - data_ready returns to 1 after edge 13.
- Back-to-back: data_valid held, 8'hFF then 8'h00 -> second MK1 appears exactly 14 cycles after the first; payloads are all-ones, then all-zeros.
- Ignore while busy: pulse data_valid with 8'h3C in mid-payload of an 8'h81 frame -> the line shows only 1,0,1,1,0,0,0,0,0,0,1,0,0; no 8'h3C frame follows.
- Reset mid-frame: assert reset during the 4th payload bit -> out=0 and data_ready=1 after that edge; no done pulse; the next accepted 8'h5A frame is clean.
- Parameter sweep: DATA_W=4, IDLE_GAP=1, data_in=4'h0 -> out=1,0,1,0,0,0,0,0 with done on the 8th cycle; DATA_W=1, data_in=1 -> 1,0,1,1,0.
